// File: rtl/mux4a1_rr_sched_pkg.sv
// Shared definitions for the 4-lane round-robin mux scheduler.
package mux4a1_rr_sched_pkg;

    localparam int unsigned N_LANES = 4;
    localparam int unsigned SEL_W   = 2;
    localparam int unsigned CNT_W   = 4;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    typedef struct packed {
        logic             found;
        logic [SEL_W-1:0] lane;
    } pick_t;

    // First requesting lane scanning cyclically from last+1; last itself is scanned last.
    function automatic pick_t next_lane(input logic [N_LANES-1:0] req_eff,
                                        input logic [SEL_W-1:0]   last);
        pick_t            res;
        logic [SEL_W-1:0] idx;
        res = '0;
        for (int k = 1; k <= int'(N_LANES); k++) begin
            idx = SEL_W'(int'(last) + k);
            if (!res.found && req_eff[idx]) begin
                res.found = 1'b1;
                res.lane  = idx;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/mux4a1_rr_sched_rr_pick4.sv
// Combinational cyclic priority picker over four request lines.
module rr_pick4
    import mux4a1_rr_sched_pkg::*;
(
    input  logic [N_LANES-1:0] req_eff,
    input  logic [SEL_W-1:0]   last,
    output logic [SEL_W-1:0]   lane,
    output logic               found
);

    pick_t pick;

    // Search starts one past the previously served lane.
    always_comb begin
        pick  = next_lane(req_eff, last);
        lane  = pick.lane;
        found = pick.found;
    end

endmodule

// File: rtl/mux4a1_rr_sched.sv
// Round-robin scheduler sharing a registered 4:1 mux between four lane FIFOs.
module mux4a1_rr_sched
    import mux4a1_rr_sched_pkg::*;
#(
    parameter int unsigned BURST = 4,
    parameter int unsigned LAT   = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [N_LANES-1:0] req,
    input  logic [N_LANES-1:0] lane_mask,
    input  logic               down_pause,
    output logic [SEL_W-1:0]   selector,
    output logic [N_LANES-1:0] pop,
    output logic               busy,
    output logic               expect_valid,
    output logic               drained
);

    localparam logic [CNT_W-1:0] BURST_LAST = CNT_W'(BURST - 1);

    state_t             state;
    logic [SEL_W-1:0]   grant;
    logic [SEL_W-1:0]   last;
    logic [CNT_W-1:0]   burst_cnt;
    logic [LAT-1:0]     inflight;

    logic [N_LANES-1:0] req_eff;
    logic [SEL_W-1:0]   pick_base;
    logic [SEL_W-1:0]   pick_lane;
    logic               pick_found;
    logic               pop_any;

    assign req_eff = req & lane_mask;

    // While granting, the current lane is the rotation origin; when idle, the last served lane is.
    assign pick_base = (state == GRANT) ? grant : last;

    rr_pick4 u_pick (
        .req_eff (req_eff),
        .last    (pick_base),
        .lane    (pick_lane),
        .found   (pick_found)
    );

    // Pop the granted lane whenever it has a word and downstream is not paused.
    always_comb begin
        pop = '0;
        if (state == GRANT && req_eff[grant] && !down_pause) begin
            pop[grant] = 1'b1;
        end
    end

    assign pop_any      = |pop;
    assign selector     = grant;
    assign busy         = (state == GRANT);
    assign expect_valid = inflight[LAT-1];
    assign drained      = (state == IDLE) && !pop_any && (inflight == '0);

    // Grant state machine: entry, burst counting, rotation on burst end or empty lane.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            grant     <= '0;
            last      <= SEL_W'(N_LANES - 1);
            burst_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_found) begin
                        state     <= GRANT;
                        grant     <= pick_lane;
                        burst_cnt <= '0;
                    end
                end
                GRANT: begin
                    if (!down_pause) begin
                        if (req_eff[grant]) begin
                            if (burst_cnt == BURST_LAST) begin
                                last      <= grant;
                                grant     <= pick_lane;
                                burst_cnt <= '0;
                                if (!pick_found) begin
                                    state <= IDLE;
                                end
                            end else begin
                                burst_cnt <= burst_cnt + CNT_W'(1);
                            end
                        end else begin
                            last      <= grant;
                            burst_cnt <= '0;
                            if (pick_found) begin
                                grant <= pick_lane;
                            end else begin
                                state <= IDLE;
                            end
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // In-flight pipe mirroring the mux latency; its tail marks mux output valid.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            inflight <= '0;
        end else begin
            for (int i = int'(LAT) - 1; i > 0; i--) begin
                inflight[i] <= inflight[i-1];
            end
            inflight[0] <= pop_any;
        end
    end

endmodule

// File: doc/mux4a1_rr_sched.md
Name: mux4a1_rr_sched

Overview:
- Round-robin scheduler that shares the 4-lane, 4-bit registered 4:1 mux between four requesting lane FIFOs.
- Each cycle it chooses the lane, drives the 2-bit mux selector, pops the granted lane FIFO, and predicts when the mux output valid will appear (mux latency LAT cycles).
- Sits between the per-lane FIFO empty flags and the mux select input. Provides downstream pause and a per-lane enable mask.

Parameters:
- BURST, 4: maximum consecutive words granted to one lane before rotating (1..15).
- LAT, 2: cycles from a pop/selector cycle to the corresponding mux output valid (1..4).

Ports:
- clk  in  1  single clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- req  in  4  lane FIFO non-empty flags; bit i = lane i has a word.
- lane_mask  in  4  lane enable; bit i = 0 excludes lane i from arbitration.
- down_pause  in  1  downstream pause; no pops while high.
- selector  out  2  registered mux select = current grant lane.
- pop  out  4  one-hot FIFO pop, combinational from registered state and inputs.
- busy  out  1  registered; 1 while the state is GRANT.
- expect_valid  out  1  registered; high exactly LAT cycles after each pop cycle.
- drained  out  1  combinational; 1 when the state is IDLE, no pop this cycle, and no words are in flight.

Behaviour:
- Reset (async, immediate): state=IDLE, grant=0, last=3 (lane 0 has first priority), burst_cnt=0, in-flight shift register=0.
  - Outputs under reset: selector=0, busy=0, expect_valid=0, pop=0000, drained=1.
- req_eff = req & lane_mask.
- next-lane search: the first set bit of req_eff scanning cyclically from last+1. The current lane is considered last, so a lone requester keeps the grant.
- IDLE:
  - If req_eff != 0, go to GRANT at the edge. grant = search result, burst_cnt=0.
  - The first pop occurs the following cycle, so there is 1 cycle of latency from req to pop.
- GRANT, pop condition: pop[grant] = req_eff[grant] & ~down_pause. All other pop bits are 0.
- GRANT, pop cycle:
  - burst_cnt increments.
  - If burst_cnt == BURST-1, rotate at this edge: last=grant, grant=search(next), burst_cnt=0. The new lane pops the next cycle with no bubble.
  - If no other lane and not the current lane requests, go to IDLE.
- GRANT, req_eff[grant]=0 and no pause (lane emptied or masked):
  - That cycle is a bubble.
  - Rotate at the edge as above, or go to IDLE if req_eff=0.
  - burst_cnt resets.
- down_pause=1: pop=0. grant, burst_cnt and selector are held. A pause is never a reason to rotate.
- selector always equals the registered grant. It changes only at rotation or entry edges, so the mux samples selector and data in the same cycle as the pop.
- In-flight tracking: a LAT-bit shift register shifts in (|pop) each cycle. expect_valid is its tail bit.
- Simultaneous events:
  - Pause in the last burst cycle: no pop, no rotation.
  - Mask change: takes effect the same cycle through req_eff.
- Reset mid-burst: pop falls asynchronously with reset. The in-flight shift register is cleared. After release, the first grant goes to lane 0 if requesting.

Decomposition:
- Shared package holds:
  - constants N_LANES=4 and SEL_W=2;
  - state encoding IDLE=1'b0, GRANT=1'b1;
  - a function next_lane(req_eff, last) returning the 2-bit lane and a found flag.
- Natural sub-module: rr_pick4, the combinational cyclic priority picker (req_eff, last -> lane, found). It is reusable by other lane schedulers.
- The in-flight shift register stays inline.

Test Plan (BURST=4, LAT=2):
- Reset held 3 cycles with req=1111 -> selector=0, pop=0000, busy=0, expect_valid=0, drained=1 throughout. After release, pop=0001 at the second cycle.
- req=0001 constant 10 cycles -> pop=0001 every cycle from cycle 1, selector=0 constant, expect_valid high from cycle 3, no rotation gap.
- req=1111 constant -> pop sequence 0001 x4, 0010 x4, 0100 x4, 1000 x4, then 0001 again. selector 0,1,2,3 with zero bubbles.
- req=1111; down_pause=1 for 3 cycles after 2 lane-1 pops -> pop=0000 for 3 cycles, selector stays 1, then 2 more lane-1 pops, then lane 2.
- lane_mask=1010, req=1111 -> only lanes 1 and 3 in alternating 4-word bursts; pop[0] and pop[2] never assert.
- Granted lane 2 with req going 0100 -> 0001 after 1 word -> one bubble cycle, then lane 0 granted. Assert reset mid-burst -> pop=0000 immediately, and drained=1 after release.
